// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared RV32I load/store encodings and LSU state type.
// Rev 1.0
`default_nettype none

package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_t;

  // Stores only come in signed-less SB/SH/SW flavours; loads add the unsigned forms.
  function automatic logic f3_legal(input logic write, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    if (write) begin
      ok = (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    end else begin
      ok = (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
    end
    return ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: core request/response and data-memory port bundle.
// Rev 1.0
`default_nettype none

interface load_store_unit_if #(
  parameter int ADDR_W = 32
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rd;

  logic              resp_valid;
  logic              resp_wen;
  logic [4:0]        resp_rd;
  logic [31:0]       resp_data;
  logic              fault;
  logic              busy;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // Environment side: the core issuing requests and the memory answering them.
  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    output mem_ack, mem_rdata,
    input  req_ready, resp_valid, resp_wen, resp_rd, resp_data, fault, busy,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, req_rd,
    input  mem_ack, mem_rdata,
    output req_ready, resp_valid, resp_wen, resp_rd, resp_data, fault, busy,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

endinterface

`default_nettype wire

// File: rtl/load_store_unit_align.sv
// lsu_align: byte enables, store-lane replication, load extraction and request checking.
// Rev 1.0
`default_nettype none

module lsu_align
  import rv32i_pkg::*;
(
  input  logic        write_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        bad_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        misaligned;

  always_comb begin
    be_o       = 4'b0000;
    wdata_o    = wdata_i;
    misaligned = 1'b0;
    // funct3[1:0] encodes access size for every legal load and store.
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_o       = 4'b0011 << addr_lo_i;
        wdata_o    = {2{wdata_i[15:0]}};
        misaligned = addr_lo_i[0];
      end
      2'b10: begin
        be_o       = 4'b1111;
        wdata_o    = wdata_i;
        misaligned = (addr_lo_i != 2'b00);
      end
      default: begin
        be_o       = 4'b0000;
        wdata_o    = wdata_i;
        misaligned = 1'b0;
      end
    endcase
  end

  assign bad_o = misaligned | ~f3_legal(write_i, funct3_i);

  always_comb begin
    byte_sel = 8'h00;
    case (addr_lo_i)
      2'b00:   byte_sel = rdata_i[7:0];
      2'b01:   byte_sel = rdata_i[15:8];
      2'b10:   byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
  end

  assign half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    rdata_o = 32'h0000_0000;
    case (funct3_i)
      F3_LB:   rdata_o = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   rdata_o = {{16{half_sel[15]}}, half_sel};
      F3_LW:   rdata_o = rdata_i;
      F3_LBU:  rdata_o = {24'h000000, byte_sel};
      F3_LHU:  rdata_o = {16'h0000, half_sel};
      default: rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I load/store unit driving a handshaked word memory.
// Rev 1.0
`default_nettype none

module load_store_unit
  import rv32i_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic clk,
  input  logic rst,
  load_store_unit_if.slave bus
);

  lsu_state_t        state_q, state_d;
  logic              write_q, write_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic [4:0]        rd_q, rd_d;
  logic              fault_q, fault_d;
  logic [31:0]       resp_data_q, resp_data_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;

  logic              use_req;
  logic              al_write;
  logic [2:0]        al_funct3;
  logic [1:0]        al_addr_lo;
  logic [3:0]        al_be;
  logic [31:0]       al_wdata;
  logic [31:0]       al_rdata;
  logic              al_bad;

  // One aligner serves both phases: request fields in IDLE, latched fields afterwards.
  assign use_req    = (state_q == IDLE);
  assign al_write   = use_req ? bus.req_write  : write_q;
  assign al_funct3  = use_req ? bus.req_funct3 : funct3_q;
  assign al_addr_lo = use_req ? bus.req_addr[1:0] : addr_lo_q;

  lsu_align u_align (
    .write_i   (al_write),
    .funct3_i  (al_funct3),
    .addr_lo_i (al_addr_lo),
    .wdata_i   (bus.req_wdata),
    .rdata_i   (bus.mem_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata),
    .bad_o     (al_bad)
  );

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    funct3_d    = funct3_q;
    addr_lo_d   = addr_lo_q;
    rd_d        = rd_q;
    fault_d     = fault_q;
    resp_data_d = resp_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d     = bus.req_write;
          funct3_d    = bus.req_funct3;
          addr_lo_d   = bus.req_addr[1:0];
          rd_d        = bus.req_rd;
          resp_data_d = 32'h0000_0000;
          if (al_bad) begin
            fault_d = 1'b1;
            state_d = RESP;
          end else begin
            fault_d     = 1'b0;
            mem_req_d   = 1'b1;
            mem_we_d    = bus.req_write;
            mem_addr_d  = {bus.req_addr[ADDR_W-1:2], 2'b00};
            mem_be_d    = al_be;
            mem_wdata_d = al_wdata;
            state_d     = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (bus.mem_ack) begin
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_be_d    = 4'b0000;
          resp_data_d = write_q ? 32'h0000_0000 : al_rdata;
          state_d     = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Async reset also drops mem_req the moment rst falls, abandoning any access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      funct3_q    <= 3'b000;
      addr_lo_q   <= 2'b00;
      rd_q        <= 5'd0;
      fault_q     <= 1'b0;
      resp_data_q <= 32'h0000_0000;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      funct3_q    <= funct3_d;
      addr_lo_q   <= addr_lo_d;
      rd_q        <= rd_d;
      fault_q     <= fault_d;
      resp_data_q <= resp_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.busy       = (state_q == ACCESS) || (state_q == RESP);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.fault      = (state_q == RESP) & fault_q;
  assign bus.resp_wen   = (state_q == RESP) & ~write_q & ~fault_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mem_req    = mem_req_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_be     = mem_be_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed scoreboard bench for load_store_unit.
// Rev 1.0
`default_nettype none

module tb_load_store_unit;

  typedef struct packed {
    logic        fault;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
  } resp_t;

  logic  clk;
  logic  rst;
  resp_t sb[$];
  int    n_assert;
  int    n_fail;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  load_store_unit #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Response monitor: every resp_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (bus.resp_valid === 1'b1) begin
      chk("resp_expected", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        resp_t e;
        e = sb.pop_front();
        chk("resp_fault", {31'd0, bus.fault}, {31'd0, e.fault});
        chk("resp_wen",   {31'd0, bus.resp_wen}, {31'd0, e.wen});
        chk("resp_rd",    {27'd0, bus.resp_rd}, {27'd0, e.rd});
        chk("resp_data",  bus.resp_data, e.data);
      end
    end
  end

  // Presents one request in the IDLE cycle; returns #1 after the handshake edge.
  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.req_rd     = rd;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Holds off the ack for dly cycles, checking the memory port each cycle.
  task automatic serve(input int dly, input logic [31:0] rdata, input logic [31:0] e_addr,
                       input logic [3:0] e_be, input logic e_we, input logic [31:0] e_wd,
                       input bit toggle);
    for (int i = 0; i <= dly; i++) begin
      chk("mem_req",   {31'd0, bus.mem_req}, 32'd1);
      chk("mem_addr",  bus.mem_addr, e_addr);
      chk("mem_be",    {28'd0, bus.mem_be}, {28'd0, e_be});
      chk("mem_we",    {31'd0, bus.mem_we}, {31'd0, e_we});
      chk("mem_wdata", bus.mem_wdata, e_wd);
      chk("busy_acc",  {31'd0, bus.busy}, 32'd1);
      chk("ready_acc", {31'd0, bus.req_ready}, 32'd0);
      if (toggle) begin
        bus.req_valid = ~bus.req_valid;
        bus.req_addr  = 32'h0000_0041;
      end
      if (i == dly) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = rdata;
      end
      @(posedge clk);
      #1;
    end
    bus.mem_ack   = 1'b0;
    bus.req_valid = 1'b0;
    chk("resp_valid_c2", {31'd0, bus.resp_valid}, 32'd1);
    chk("mem_req_off",   {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("resp_pulse_end", {31'd0, bus.resp_valid}, 32'd0);
    chk("ready_back",     {31'd0, bus.req_ready}, 32'd1);
  endtask

  task automatic fault_op(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [4:0] rd);
    sb.push_back('{fault: 1'b1, wen: 1'b0, rd: rd, data: 32'h0});
    issue(w, f3, a, 32'h1234_5678, rd);
    chk("fault_c1",        {31'd0, bus.fault}, 32'd1);
    chk("fault_no_memreq", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("fault_ready_c2",  {31'd0, bus.req_ready}, 32'd1);
    chk("fault_no_memreq2", {31'd0, bus.mem_req}, 32'd0);
  endtask

  task automatic load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                      input logic [31:0] word, input logic [3:0] e_be, input logic [31:0] e_data);
    sb.push_back('{fault: 1'b0, wen: 1'b1, rd: rd, data: e_data});
    issue(1'b0, f3, a, 32'h0, rd);
    serve(0, word, {a[31:2], 2'b00}, e_be, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                       input logic [4:0] rd, input logic [3:0] e_be, input logic [31:0] e_wd);
    sb.push_back('{fault: 1'b0, wen: 1'b0, rd: rd, data: 32'h0});
    issue(1'b1, f3, a, wd, rd);
    serve(0, 32'hDEAD_BEEF, {a[31:2], 2'b00}, e_be, 1'b1, e_wd, 1'b0);
  endtask

  initial begin
    n_assert       = 0;
    n_fail         = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_rd     = 5'd0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = 32'h0;

    #12;
    chk("rst_ready",     {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mem_req",   {31'd0, bus.mem_req}, 32'd0);
    chk("rst_mem_we",    {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_be",    {28'd0, bus.mem_be}, 32'd0);
    chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    chk("rst_resp_wen",  {31'd0, bus.resp_wen}, 32'd0);
    chk("rst_fault",     {31'd0, bus.fault}, 32'd0);
    chk("rst_busy",      {31'd0, bus.busy}, 32'd0);
    chk("rst_mem_addr",  bus.mem_addr, 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_resp_data", bus.resp_data, 32'd0);
    chk("rst_resp_rd",   {27'd0, bus.resp_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Loads of word 0x000003FE at 0x8.
    load(3'b000, 32'h8, 5'd20, 32'h0000_03FE, 4'b0001, 32'hFFFF_FFFE);
    load(3'b001, 32'h8, 5'd20, 32'h0000_03FE, 4'b0011, 32'h0000_03FE);
    load(3'b100, 32'h8, 5'd20, 32'h0000_03FE, 4'b0001, 32'h0000_00FE);
    load(3'b101, 32'h8, 5'd20, 32'h0000_03FE, 4'b0011, 32'h0000_03FE);
    load(3'b010, 32'h8, 5'd20, 32'h0000_03FE, 4'b1111, 32'h0000_03FE);
    // Upper lanes.
    load(3'b000, 32'hB, 5'd9, 32'h8000_0000, 4'b1000, 32'hFFFF_FF80);
    load(3'b101, 32'hA, 5'd10, 32'h8001_0000, 4'b1100, 32'h0000_8001);
    load(3'b001, 32'h2, 5'd11, 32'h8001_0000, 4'b1100, 32'hFFFF_8001);

    // Stores.
    store(3'b000, 32'hC, 32'hFFFF_FFFF, 5'd5, 4'b0001, 32'hFFFF_FFFF);
    store(3'b000, 32'hD, 32'hFFFF_FFFF, 5'd5, 4'b0010, 32'hFFFF_FFFF);
    store(3'b001, 32'hE, 32'h0000_ABCD, 5'd6, 4'b1100, 32'hABCD_ABCD);
    store(3'b010, 32'h10, 32'h1357_9BDF, 5'd7, 4'b1111, 32'h1357_9BDF);

    // Misaligned and illegal requests.
    fault_op(1'b0, 3'b010, 32'hA, 5'd7);
    fault_op(1'b0, 3'b001, 32'h9, 5'd8);
    fault_op(1'b0, 3'b011, 32'h0, 5'd12);
    fault_op(1'b1, 3'b100, 32'h0, 5'd13);
    fault_op(1'b1, 3'b001, 32'h3, 5'd14);

    // Delayed ack with req_valid toggling underneath.
    sb.push_back('{fault: 1'b0, wen: 1'b1, rd: 5'd3, data: 32'h1234_5678});
    issue(1'b0, 3'b010, 32'h8, 32'h0, 5'd3);
    serve(3, 32'h1234_5678, 32'h8, 4'b1111, 1'b0, 32'h0, 1'b1);

    // Reset in the middle of an access; the late ack must be ignored.
    issue(1'b0, 3'b010, 32'h8, 32'h0, 5'd4);
    chk("pre_rst_mem_req", {31'd0, bus.mem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_drop_mem_req", {31'd0, bus.mem_req}, 32'd0);
    chk("rst_drop_ready",   {31'd0, bus.req_ready}, 32'd1);
    chk("rst_drop_busy",    {31'd0, bus.busy}, 32'd0);
    @(negedge clk);
    rst           = 1'b1;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5555_AAAA;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
    chk("late_ack_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    chk("late_ack_mem_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clk);
    #1;
    chk("late_ack_no_resp2", {31'd0, bus.resp_valid}, 32'd0);
    chk("late_ack_ready",    {31'd0, bus.req_ready}, 32'd1);

    load(3'b010, 32'h4, 5'd15, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle load/store unit between the RV32I core's execute stage and a handshaked data memory. Accepts one load or store per transaction, checks alignment, and drives a word-addressed memory port with byte enables and lane-replicated store data. Returns sign- or zero-extended load data tagged with the destination register. Holds `busy` high so the core stalls while a memory access is outstanding.

## Interface
- `ADDR_W`, default 32: byte-address width.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  core presents a memory operation.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width/sign code.
- `req_addr`  in  ADDR_W  effective byte address.
- `req_wdata`  in  32  store source (rs2).
- `req_rd`  in  5  load destination register.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_wen`  out  1  register write enable; high with `resp_valid` for a successful load only.
- `resp_rd`  out  5  latched `req_rd`.
- `resp_data`  out  32  extended load data; 0 for stores and faults.
- `fault`  out  1  high with `resp_valid` when the request was misaligned or used an illegal funct3.
- `busy`  out  1  high in ACCESS and RESP.
- `mem_req`  out  1  memory request; held until ack.
- `mem_we`  out  1  write strobe.
- `mem_addr`  out  ADDR_W  word-aligned address, bits [1:0] = 0.
- `mem_be`  out  4  byte enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ack`  in  1  access complete; `mem_rdata` valid in the same cycle.
- `mem_rdata`  in  32  read word.

## Operation
- States:
  - IDLE: accepts requests.
  - ACCESS: memory transaction in flight.
  - RESP: reports the result for one cycle.
- IDLE:
  - A handshake completes when `req_valid & req_ready`. On that edge, latch `write`, `funct3`, `addr` and `rd`.
  - A request is legal when `funct3` is LB/LH/LW/LBU/LHU for loads, or SB/SH/SW for stores.
  - Alignment: halfword requires `addr[0]=0`; word requires `addr[1:0]=0`.
  - Illegal or misaligned request: go to RESP with `fault=1`. `mem_req` is never asserted.
  - Otherwise go to ACCESS.
- ACCESS:
  - `mem_req=1`. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` are stable until ack.
  - On `mem_ack`, capture the extended `mem_rdata` into `resp_data` and go to RESP.
- RESP: `resp_valid=1` for exactly one cycle, then IDLE.
- Byte enables:
  - byte: `0001 << addr[1:0]`
  - half: `0011 << addr[1:0]`
  - word: `1111`
- Store data:
  - byte: `{4{wdata[7:0]}}`
  - half: `{2{wdata[15:0]}}`
  - word: `wdata`
- Load extraction:
  - byte: lane selected by `addr[1:0]`.
  - half: lane selected by `addr[1]`.
  - Extension: LB and LH sign-extend; LBU and LHU zero-extend; LW passes the word through.
- Ignored inputs: `mem_ack` in IDLE or RESP; `req_*` while `busy`. The core holds its request until `req_ready`.

## Timing
- Reset (asynchronous, immediate):
  - State returns to IDLE. `req_ready=1`.
  - `mem_req`, `mem_we`, `mem_be`, `resp_valid`, `resp_wen` and `fault` are 0.
  - `busy`, `mem_addr`, `mem_wdata`, `resp_data` and `resp_rd` are 0.
- Reset mid-ACCESS drops `mem_req` combinationally with reset assertion. A late ack is ignored.
- Memory-side outputs are registered.
- Latency, with the handshake in cycle 0:
  - `mem_req` is high from cycle 1.
  - With ack in cycle 1, `resp_valid` is high in cycle 2 and `req_ready` returns in cycle 3.
  - Each wait cycle on `mem_ack` adds one cycle.
- Fault path: `resp_valid` and `fault` are high in cycle 1.
- Throughput: at most one transaction per 3 cycles, or per 2 cycles for faults.

## Structure
- Shared package `rv32i_pkg`:
  - funct3 localparams: `F3_LB`=000, `F3_LH`=001, `F3_LW`=010, `F3_LBU`=100, `F3_LHU`=101. The stores SB/SH/SW reuse 000/001/010.
  - enum `lsu_state_t` {IDLE, ACCESS, RESP}.
- Sub-module `lsu_align` (combinational):
  - Computes `mem_be` and replicated `mem_wdata` from `funct3`, `addr[1:0]` and `wdata`.
  - Computes extended load data from `mem_rdata`.
  - Computes the misaligned/illegal flag.
- Top FSM: in `load_store_unit`.

## Test plan
- Memory word @0x8 = 0x000003FE. Issue LB, LH, LBU, LHU and LW to 0x8 with `rd`=20. Required `resp_data`: 0xFFFFFFFE, 0x000003FE, 0x000000FE, 0x000003FE, 0x000003FE. `resp_wen=1` and `resp_rd`=20 each time.
- SB of 0xFFFFFFFF to 0xC, then to 0xD:
  - First: `mem_addr`=0xC, `mem_be`=0001 then 0010, `mem_wdata`=0xFFFFFFFF, `mem_we=1`.
  - Final response: `resp_wen=0`, `resp_data`=0.
- SH of 0x0000ABCD to 0xE → `mem_addr`=0xC, `be`=1100, `wdata`=0xABCDABCD.
- LW to 0xA and LH to 0x9 → `fault=1` in cycle 1. No `mem_req` asserted. `resp_wen=0`.
- LW with `mem_ack` delayed 3 cycles → `mem_req` held 4 cycles with stable address. `req_valid` toggled meanwhile is ignored. `resp_valid` is a single pulse.
- Assert `rst` low during ACCESS, then ack → `mem_req` drops immediately, no `resp_valid`, `req_ready=1`. The next LW completes normally.
